// File: rtl/out_pingpong_buffer.sv
// out_pingpong_buffer: two-bank ping-pong store for engine output packets, written from an AXI-Stream slave, read back by the host
// Ports: aclk/rst (async active-high) | s_axis_* stream input, tready stalls while both banks hold packets
//        rd_bank/rd_addr/rd_en -> rd_data one cycle later | bank_full/bank_release per-bank handshake with host
//        bank_count latched word count per bank (bank 0 in LSBs) | overflow sticky, a packet exceeded DEPTH words
// Optional: define OUT_PINGPONG_COUNT_EN to build the per-bank count registers; otherwise bank_count is tied to 0.
module out_pingpong_buffer #(
    parameter int OUT_BITS       = 32,
    parameter int OUT_ADDR_WIDTH = 10
) (
    input  logic                            aclk,
    input  logic                            rst,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    input  logic [OUT_BITS-1:0]             s_axis_tdata,
    input  logic [OUT_BITS/8-1:0]           s_axis_tkeep,
    input  logic                            rd_bank,
    input  logic [OUT_ADDR_WIDTH-1:0]       rd_addr,
    input  logic                            rd_en,
    output logic [OUT_BITS-1:0]             rd_data,
    output logic [1:0]                      bank_full,
    input  logic [1:0]                      bank_release,
    output logic [2*(OUT_ADDR_WIDTH+1)-1:0] bank_count,
    output logic                            overflow
);
    localparam int DEPTH = 2 ** OUT_ADDR_WIDTH;
    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [OUT_BITS-1:0] mem0 [DEPTH];
    logic [OUT_BITS-1:0] mem1 [DEPTH];

    logic [0:0]              state_q, state_d;
    logic                    run_q;
    logic                    wr_bank_q, wr_bank_d;
    logic [OUT_ADDR_WIDTH:0] wr_addr_q, wr_addr_d, wr_inc;
    logic [1:0]              full_q, full_d;
    logic                    ovf_q, ovf_d;
    logic [OUT_BITS-1:0]     rd_data_q, rd_data_d;
    logic                    accept, storable, store, last;

    // run_q keeps tready low while reset is held even though the state already reads FILL
    assign s_axis_tready = run_q && (state_q == FILL);
    assign bank_full     = full_q;
    assign overflow      = ovf_q;
    assign rd_data       = rd_data_q;

    always_comb begin
        accept    = s_axis_tvalid && s_axis_tready;
        storable  = accept && (|s_axis_tkeep);
        // wr_addr MSB set means the bank already holds DEPTH words
        store     = storable && !wr_addr_q[OUT_ADDR_WIDTH];
        last      = accept && s_axis_tlast;
        wr_inc    = wr_addr_q + {{OUT_ADDR_WIDTH{1'b0}}, store};
        ovf_d     = ovf_q || (storable && wr_addr_q[OUT_ADDR_WIDTH]);
        wr_addr_d = last ? '0 : wr_inc;
        wr_bank_d = wr_bank_q ^ last;
        full_d    = (full_q & ~bank_release) | ({1'b0, last} << wr_bank_q);
        // stall exactly while the bank to be filled next still holds an unreleased packet
        state_d   = full_d[wr_bank_d] ? WAIT : FILL;
        rd_data_d = rd_en ? (rd_bank ? mem1[rd_addr] : mem0[rd_addr]) : rd_data_q;
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL;
            run_q     <= 1'b0;
            wr_bank_q <= 1'b0;
            wr_addr_q <= '0;
            full_q    <= '0;
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            wr_bank_q <= wr_bank_d;
            wr_addr_q <= wr_addr_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (store && !wr_bank_q) mem0[wr_addr_q[OUT_ADDR_WIDTH-1:0]] <= s_axis_tdata;
        if (store && wr_bank_q) mem1[wr_addr_q[OUT_ADDR_WIDTH-1:0]] <= s_axis_tdata;
    end

`ifdef OUT_PINGPONG_COUNT_EN
    logic [1:0][OUT_ADDR_WIDTH:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d[0] = (last && !wr_bank_q) ? wr_inc : cnt_q[0];
        cnt_d[1] = (last && wr_bank_q) ? wr_inc : cnt_q[1];
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

    assign bank_count = cnt_q;
`else
    assign bank_count = '0;
`endif

endmodule

// File: tb/tb_out_pingpong_buffer.sv
// tb_out_pingpong_buffer: table, directed scenarios and random traffic against a packet-level reference model
module tb_out_pingpong_buffer;
    localparam int AW = 4;
    localparam int W  = 32;
`ifdef OUT_PINGPONG_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            aclk = 1'b0;
    logic            rst = 1'b1;
    logic            s_axis_tready;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tlast = 1'b0;
    logic [W-1:0]    s_axis_tdata = '0;
    logic [W/8-1:0]  s_axis_tkeep = '0;
    logic            rd_bank = 1'b0;
    logic [AW-1:0]   rd_addr = '0;
    logic            rd_en = 1'b0;
    logic [W-1:0]    rd_data;
    logic [1:0]      bank_full;
    logic [1:0]      bank_release = '0;
    logic [2*(AW+1)-1:0] bank_count;
    logic            overflow;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    out_pingpong_buffer #(.OUT_BITS(W), .OUT_ADDR_WIDTH(AW)) dut (
        .aclk(aclk), .rst(rst),
        .s_axis_tready(s_axis_tready), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .bank_full(bank_full), .bank_release(bank_release), .bank_count(bank_count), .overflow(overflow)
    );

    // packet-level reference: per-bank word arrays, fill position of the open packet, host handshake flags
    logic [W-1:0] m_mem [2][16];
    bit           m_memv [2][16];
    int           m_n, m_wb;
    bit           m_full [2];
    int           m_cnt [2];
    bit           m_ovf, m_rdy, m_rdv;
    logic [W-1:0] m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_rst();
        m_n = 0; m_wb = 0; m_ovf = 0; m_rdy = 0; m_rd = '0; m_rdv = 1;
        for (int b = 0; b < 2; b++) begin
            m_full[b] = 0; m_cnt[b] = 0;
            for (int a = 0; a < 16; a++) m_memv[b][a] = 0;
        end
    endtask

    task automatic model_edge(input bit v, input bit l, input logic [W-1:0] d, input logic [3:0] k,
                              input logic [1:0] rel, input bit re, input bit rb, input logic [AW-1:0] ra);
        bit acc;
        bit nf [2];
        if (rst) begin
            model_rst();
            return;
        end
        acc = v && m_rdy;
        if (re) begin
            m_rdv = m_memv[rb][ra];
            m_rd  = m_mem[rb][ra];
        end
        for (int b = 0; b < 2; b++) nf[b] = m_full[b] && !rel[b];
        if (acc && k != 0) begin
            if (m_n < 16) begin
                m_mem[m_wb][m_n] = d; m_memv[m_wb][m_n] = 1; m_n++;
            end else m_ovf = 1;
        end
        if (acc && l) begin
            nf[m_wb] = 1; m_cnt[m_wb] = m_n; m_n = 0; m_wb ^= 1;
        end
        m_full = nf;
        m_rdy = !m_full[m_wb];
    endtask

    task automatic compare();
        logic [2*(AW+1)-1:0] ec;
        ec = CNT_EN ? {5'(m_cnt[1]), 5'(m_cnt[0])} : '0;
        chk("tready", {31'b0, s_axis_tready}, {31'b0, m_rdy});
        chk("bank_full", {30'b0, bank_full}, {30'b0, m_full[1], m_full[0]});
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        chk("bank_count", {22'b0, bank_count}, {22'b0, ec});
        if (m_rdv) chk("rd_data", rd_data, m_rd);
    endtask

    task automatic cyc(input bit v, input bit l, input logic [W-1:0] d, input logic [3:0] k,
                       input logic [1:0] rel, input bit re, input bit rb, input logic [AW-1:0] ra);
        s_axis_tvalid = v; s_axis_tlast = l; s_axis_tdata = d; s_axis_tkeep = k;
        bank_release = rel; rd_en = re; rd_bank = rb; rd_addr = ra;
        @(posedge aclk);
        #1;
        model_edge(v, l, d, k, rel, re, rb, ra);
        compare();
    endtask

    task automatic idle();
        cyc(0, 0, '0, 4'hF, 2'b00, 0, 0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_axis_tvalid = 0; s_axis_tlast = 0; bank_release = '0; rd_en = 0;
        #1;
        model_rst();
        compare();
        chk("rst_tready", {31'b0, s_axis_tready}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_count", {22'b0, bank_count}, 32'd0);
        repeat (2) begin
            @(posedge aclk);
            #1;
            compare();
        end
        rst = 1'b0;
        idle();
    endtask

    task automatic beats(input int n, input logic [W-1:0] base, input bit end_last);
        for (int i = 0; i < n; i++) cyc(1, end_last && (i == n - 1), base + W'(i), 4'hF, 2'b00, 0, 0, '0);
    endtask

    typedef struct {
        bit           v;
        bit           l;
        logic [W-1:0] d;
        bit           re;
        logic [AW-1:0] ra;
        bit           e_rdy;
        logic [1:0]   e_full;
        int           e_cnt0;
        logic [W-1:0] e_rd;
    } vec_t;

    function automatic vec_t mk(input bit v, input bit l, input logic [W-1:0] d, input bit re,
                                input logic [AW-1:0] ra, input logic [1:0] ef, input int ec, input logic [W-1:0] er);
        vec_t t;
        t.v = v; t.l = l; t.d = d; t.re = re; t.ra = ra;
        t.e_rdy = 1'b1; t.e_full = ef; t.e_cnt0 = ec; t.e_rd = er;
        return t;
    endfunction

    initial begin
        vec_t tbl [10];
        for (int i = 0; i < 5; i++) tbl[i] = mk(1, i == 4, 32'hA0 + W'(i), 0, '0, (i == 4) ? 2'b01 : 2'b00, (i == 4) ? 5 : 0, '0);
        for (int i = 0; i < 5; i++) tbl[5 + i] = mk(0, 0, '0, 1, AW'(i), 2'b01, 5, 32'hA0 + W'(i));

        // five-beat packet into bank 0, then read it back
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].v, tbl[i].l, tbl[i].d, 4'hF, 2'b00, tbl[i].re, 0, tbl[i].ra);
            chk("tbl_tready", {31'b0, s_axis_tready}, {31'b0, tbl[i].e_rdy});
            chk("tbl_full", {30'b0, bank_full}, {30'b0, tbl[i].e_full});
            chk("tbl_count0", {27'b0, bank_count[4:0]}, CNT_EN ? tbl[i].e_cnt0 : 0);
            chk("tbl_rd_data", rd_data, tbl[i].e_rd);
        end

        // both banks full stalls the stream; releasing bank 0 resumes filling bank 0
        do_reset();
        beats(3, 32'hC0, 1);
        beats(3, 32'hC3, 1);
        chk("s2_full", {30'b0, bank_full}, 32'd3);
        chk("s2_tready", {31'b0, s_axis_tready}, 32'd0);
        cyc(1, 0, 32'hDEAD, 4'hF, 2'b00, 0, 0, '0);
        chk("s2_stall", {31'b0, s_axis_tready}, 32'd0);
        cyc(0, 0, '0, 4'hF, 2'b01, 0, 0, '0);
        chk("s2_resume", {31'b0, s_axis_tready}, 32'd1);
        chk("s2_full_after_rel", {30'b0, bank_full}, 32'd2);
        cyc(1, 0, 32'hE0, 4'hF, 2'b00, 1, 0, '0);
        chk("s2_read_old", rd_data, 32'hC0);
        cyc(1, 1, 32'hE1, 4'hF, 2'b00, 0, 0, '0);
        chk("s2_refull", {30'b0, bank_full}, 32'd3);
        cyc(0, 0, '0, 4'hF, 2'b00, 1, 0, '0);
        chk("s2_bank0_new", rd_data, 32'hE0);
        cyc(0, 0, '0, 4'hF, 2'b10, 0, 0, '0);
        chk("s2_rel1", {31'b0, s_axis_tready}, 32'd1);

        // exactly DEPTH words does not overflow; 20 words keeps the first 16 and flags overflow
        do_reset();
        beats(16, 32'hD0, 1);
        chk("s3_exact_ovf", {31'b0, overflow}, 32'd0);
        chk("s3_exact_count", {27'b0, bank_count[4:0]}, CNT_EN ? 16 : 0);
        do_reset();
        beats(20, 32'h100, 1);
        chk("s3_ovf", {31'b0, overflow}, 32'd1);
        chk("s3_count", {27'b0, bank_count[4:0]}, CNT_EN ? 16 : 0);
        chk("s3_full", {30'b0, bank_full}, 32'd1);
        for (int a = 0; a < 16; a++) begin
            cyc(0, 0, '0, 4'hF, 2'b00, 1, 0, AW'(a));
            chk("s3_read", rd_data, 32'h100 + a);
        end

        // empty-keep beat carrying tlast closes the packet without storing
        do_reset();
        beats(2, 32'h40, 0);
        cyc(1, 1, 32'hBAD, 4'h0, 2'b00, 0, 0, '0);
        chk("s4_full", {30'b0, bank_full}, 32'd1);
        chk("s4_count", {27'b0, bank_count[4:0]}, CNT_EN ? 2 : 0);
        beats(1, 32'h50, 1);
        cyc(0, 0, '0, 4'hF, 2'b00, 1, 1, '0);
        chk("s4_bank1", rd_data, 32'h50);

        // bank 1 released in the same cycle bank 0 completes: no stall
        do_reset();
        beats(1, 32'h60, 1);
        cyc(0, 0, '0, 4'hF, 2'b01, 0, 0, '0);
        beats(1, 32'h61, 1);
        chk("s5_setup", {30'b0, bank_full}, 32'd2);
        cyc(1, 0, 32'h62, 4'hF, 2'b00, 0, 0, '0);
        chk("s5_tready_a", {31'b0, s_axis_tready}, 32'd1);
        cyc(1, 1, 32'h63, 4'hF, 2'b10, 0, 0, '0);
        chk("s5_tready_b", {31'b0, s_axis_tready}, 32'd1);
        chk("s5_full", {30'b0, bank_full}, 32'd1);
        idle();
        chk("s5_tready_c", {31'b0, s_axis_tready}, 32'd1);

        // reset mid-packet discards it; the next packet starts at bank 0 address 0
        do_reset();
        for (int i = 0; i < 7; i++) cyc(1, 0, 32'h70 + W'(i), 4'hF, 2'b00, i == 5, 0, 4'd2);
        chk("s6_pre_rd", rd_data, 32'h72);
        do_reset();
        beats(2, 32'h90, 1);
        cyc(0, 0, '0, 4'hF, 2'b00, 1, 0, 4'd0);
        chk("s6_rd0", rd_data, 32'h90);
        cyc(0, 0, '0, 4'hF, 2'b00, 1, 0, 4'd1);
        chk("s6_rd1", rd_data, 32'h91);
        chk("s6_count", {22'b0, bank_count}, CNT_EN ? 2 : 0);

        // random traffic against the reference model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(9) < 7, $urandom_range(7) == 0, $urandom,
                ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom_range(15) | 1),
                {$urandom_range(3) == 0, $urandom_range(3) == 0},
                $urandom_range(1) == 1, $urandom_range(1) == 1, 4'($urandom_range(15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/out_pingpong_buffer.md
OUT_PINGPONG_BUFFER -- requirements
Module: out_pingpong_buffer

Interface
REQ-001 The block SHALL have parameter OUT_BITS, default 32, giving the width of one stored output word and of the stream data.
REQ-002 The block SHALL have parameter OUT_ADDR_WIDTH, default 10, giving the bank depth DEPTH = 2**OUT_ADDR_WIDTH words.
REQ-003 The block SHALL have port aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset, asynchronous and active-high.
REQ-005 The block SHALL have port s_axis_tready, output, 1, the stream ready signal.
REQ-006 The block SHALL have port s_axis_tvalid, input, 1, the stream valid signal.
REQ-007 The block SHALL have port s_axis_tlast, input, 1, marking the end of a tile packet.
REQ-008 The block SHALL have port s_axis_tdata, input, OUT_BITS, the engine output word.
REQ-009 The block SHALL have port s_axis_tkeep, input, OUT_BITS/8, the per-byte keep.
REQ-010 The block SHALL have port rd_bank, input, 1, the bank selected for a read.
REQ-011 The block SHALL have port rd_addr, input, OUT_ADDR_WIDTH, the read word address.
REQ-012 The block SHALL have port rd_en, input, 1, the read strobe.
REQ-013 The block SHALL have port rd_data, output, OUT_BITS, the read word.
REQ-014 The block SHALL have port bank_full, output, 2, one bit per bank indicating a completed packet is held.
REQ-015 The block SHALL have port bank_release, input, 2, a per-bank host release pulse.
REQ-016 The block SHALL have port bank_count, output, 2*(OUT_ADDR_WIDTH+1), the stored word count per bank with bank 0 in the LSBs.
REQ-017 The block SHALL have port overflow, output, 1, a sticky flag that a packet exceeded DEPTH.

Function
REQ-018 A beat SHALL be accepted when s_axis_tvalid and s_axis_tready are both 1; s_axis_tready SHALL be driven from the FSM state only and SHALL have no combinational path from s_axis_tvalid.
REQ-019 The FSM SHALL have two states:
- FILL: s_axis_tready=1.
- WAIT: s_axis_tready=0.
REQ-020 The block SHALL keep internal registers wr_bank (the bank being filled) and wr_addr (the next write address).
REQ-021 An accepted beat with any s_axis_tkeep bit set and wr_addr < DEPTH SHALL write s_axis_tdata to bank[wr_bank][wr_addr] and increment wr_addr.
REQ-022 An accepted beat with tkeep all zero SHALL store nothing and SHALL leave wr_addr unchanged, while its tlast is still honoured.
REQ-023 An accepted storable beat arriving when wr_addr == DEPTH SHALL be dropped and SHALL set overflow, which stays 1 until reset.
REQ-024 An accepted beat with tlast=1 SHALL, on the next edge:
- set bank_full[wr_bank];
- latch that bank's count, including the final beat if stored;
- clear wr_addr;
- toggle wr_bank.
REQ-025 At a tlast acceptance, the FSM SHALL go FILL->WAIT if the other bank is full and not released in the same cycle; otherwise it SHALL stay in FILL.
REQ-026 In WAIT, the FSM SHALL return to FILL on the edge that clears bank_full[wr_bank].
REQ-027 bank_release[b]=1 SHALL clear bank_full[b] on the next edge and SHALL be ignored when bank_full[b]=0; the bank currently filling is never full, so releasing it has no effect.
REQ-028 A release and a tlast targeting different banks in the same cycle SHALL both take effect.
REQ-029 A release in the same cycle as a tlast whose toggle targets the released bank SHALL leave the FSM in FILL.
REQ-030 Reads SHALL have 1-cycle latency: on an edge with rd_en=1, rd_data SHALL load bank[rd_bank][rd_addr]; otherwise rd_data holds.
REQ-031 Reads SHALL be permitted on either bank regardless of bank_full.
REQ-032 A read of the address being written in the same cycle SHALL return the old contents.
REQ-033 Bank contents SHALL be inferable as simple dual-port RAM, one per bank, with no reset on the array.

Reset
REQ-034 While rst=1, the block SHALL force s_axis_tready=0, bank_full=0, bank_count=0, overflow=0, rd_data=0, wr_bank=0, wr_addr=0 and state=FILL; s_axis_tready SHALL become 1 on the first edge after rst falls.
REQ-035 Reset asserted mid-packet SHALL discard the partial packet; bank array contents are undefined after reset.

Configuration
REQ-036 With macro OUT_PINGPONG_COUNT_EN defined, bank_count SHALL report the latched word count per bank (0..DEPTH), held until the next tlast into that bank and not cleared by release.
REQ-037 With OUT_PINGPONG_COUNT_EN undefined, bank_count SHALL be tied to 0, no count registers SHALL be synthesised, and all other behaviour SHALL be unchanged.

Verification
REQ-038 The bench SHALL run at OUT_ADDR_WIDTH=4 (DEPTH=16), OUT_BITS=32, with OUT_PINGPONG_COUNT_EN defined unless stated.
REQ-039 Scenario 1: 5 beats 0xA0..0xA4, tlast on the 5th -> bank_full=01, count0=5; reading bank0 addr 0..4 returns 0xA0..0xA4 one cycle after each rd_en.
REQ-040 Scenario 2: two 3-beat packets, no release -> bank_full=11 and s_axis_tready=0; pulse bank_release=01 -> tready=1 on the next cycle with wr_bank=0.
REQ-041 Scenario 3: 20-beat packet -> count0=16 and overflow=1; beats 17..20 absent from bank0.
REQ-042 Scenario 4: a beat with tkeep=0 and tlast=1 after 2 valid beats -> count0=2 and bank_full[0]=1.
REQ-043 Scenario 5: bank1 full, tlast into bank0 while bank_release=10 in the same cycle -> FSM stays in FILL, bank_full=01, tready never drops.
REQ-044 Scenario 6: rst pulsed after 7 beats, with and without OUT_PINGPONG_COUNT_EN -> all outputs 0; a new 2-beat packet lands at bank0 addr 0..1; bank_count is always 0 when the macro is undefined.
